filter_capture: RTL and testbench
=================================

Name: filter_capture

Overview:
Triggered capture buffer at the output end of the FIR signal path: records the filtered stream (o_filtered_signal of top_design) into an on-chip buffer and plays it back over a valid/ready read port. Capture starts on a signed rising threshold crossing. It is the hardware counterpart of the bench probe, so filter output can be read out on-board after synthesis.

Parameters:
N_PROBE, 8, sample width in bits; two's-complement signed.
N_DEPTH_LOG2, 5, log2 of buffer depth (DEPTH = 32 samples).

Ports:
clock  input  1  system clock; all logic on the rising edge.
i_reset  input  1  synchronous reset, active-high.
i_sample  input  N_PROBE  filtered sample, signed.
i_sample_valid  input  1  i_sample is valid this cycle (1 sample per strobe).
i_arm  input  1  single-cycle arm request.
i_threshold  input  N_PROBE  signed trigger level, sampled every cycle.
o_data  output  N_PROBE  readout sample.
o_valid  output  1  o_data valid.
i_ready  input  1  consumer accepts o_data.
o_state  output  2  00 IDLE, 01 ARMED, 10 CAPTURE, 11 READOUT.
o_done  output  1  one-cycle pulse when the last sample is accepted.

Behaviour:
- Reset (clock edge with i_reset=1): state IDLE; o_data=0, o_valid=0, o_done=0, o_state=00; write pointer, read pointer, prev-sample register and prev_ok flag cleared. Buffer contents are not cleared. Reset mid-operation aborts immediately with the same values.
- IDLE: i_arm=1 -> ARMED next cycle, prev_ok=0. Other inputs ignored.
- ARMED: on each i_sample_valid: if prev_ok and prev < i_threshold and i_sample >= i_threshold (signed compare) -> CAPTURE. The triggering sample is written at index 0 and wr_ptr=1. Every valid sample loads prev and sets prev_ok. The first valid sample after arming never triggers.
- CAPTURE: each i_sample_valid writes i_sample at wr_ptr, wr_ptr++. After index DEPTH-1 is written -> READOUT, rd_ptr=0. Invalid cycles write nothing. Exactly DEPTH samples are captured, including the trigger sample.
- READOUT: o_valid=1 from the first READOUT cycle (registered read, so one idle cycle after entry is allowed before o_valid rises). o_data = buffer[rd_ptr].
  - Transfer on o_valid && i_ready; rd_ptr++.
  - o_data and o_valid stay stable while i_ready=0.
  - After the transfer of index DEPTH-1: o_valid=0, o_done=1 for exactly one cycle, state IDLE.
- i_arm is ignored in ARMED, CAPTURE and READOUT. i_sample_valid is ignored in IDLE and READOUT.
- Pointers are N_DEPTH_LOG2 bits wide; the end of capture or readout is detected on pointer value DEPTH-1 plus the handshake, never on wrap.
- No arithmetic on samples beyond the signed compare; samples are stored bit-exact.

Test Plan:
- Reset: i_reset held 5 cycles mid-CAPTURE -> o_state=00, o_valid=0, o_done=0 the cycle after; i_arm then re-arms normally.
- Basic trigger: threshold=0, arm, then valid samples -5,-1,3,7,... (+4 each) -> trigger on 3. Readout yields 3,7,11,...,127 (32 values); o_done pulses once; o_state back to 00.
- Signed boundary: threshold=-10, samples 127,-128,-11,-10 -> no trigger on 127 or -128 (first sample / no crossing), trigger on -10. Captured index0 = 0xF6.
- No false trigger: first valid sample after arm = 50, threshold=20, previous pre-arm sample 0 -> no trigger. Then samples 10,25 -> trigger on 25.
- Backpressure: i_ready toggled 1,0,0,1 pattern -> o_data constant while stalled; exactly 32 transfers, no duplicates or drops. i_sample_valid gaps during CAPTURE (1 of 3 cycles) -> still exactly 32 stored in order.
- Ignored inputs: i_arm pulses during CAPTURE and READOUT, and i_sample_valid during READOUT -> no state change, readout data unchanged.

Source files
------------

// File: rtl/filter_capture.sv
// Triggered capture buffer: waits for a signed rising threshold crossing, stores
// DEPTH consecutive samples, then plays them back over a valid/ready read port.
module filter_capture #(
  parameter int unsigned N_PROBE      = 8,
  parameter int unsigned N_DEPTH_LOG2 = 5
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic [N_PROBE-1:0] i_sample,
  input  logic               i_sample_valid,
  input  logic               i_arm,
  input  logic [N_PROBE-1:0] i_threshold,
  output logic [N_PROBE-1:0] o_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [1:0]         o_state,
  output logic               o_done
);

  localparam int unsigned Depth = 1 << N_DEPTH_LOG2;

  typedef logic [N_DEPTH_LOG2-1:0] ptr_t;
  localparam ptr_t LastIdx = ptr_t'(Depth - 1);

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StArmed   = 2'b01,
    StCapture = 2'b10,
    StReadout = 2'b11
  } state_e;

  state_e             state_q, state_d;
  logic [N_PROBE-1:0] mem [Depth];
  ptr_t               wr_ptr_q, rd_ptr_q, rd_next;
  logic [N_PROBE-1:0] prev_q, data_q;
  logic               prev_ok_q, valid_q, done_q;
  logic               trigger, xfer, mem_we;
  ptr_t               mem_addr;

  assign trigger = prev_ok_q && ($signed(prev_q) < $signed(i_threshold)) &&
                   ($signed(i_sample) >= $signed(i_threshold));
  assign xfer    = valid_q && i_ready;
  assign rd_next = rd_ptr_q + ptr_t'(1);

  always_comb begin
    state_d  = state_q;
    mem_we   = 1'b0;
    mem_addr = wr_ptr_q;
    unique case (state_q)
      StIdle: begin
        if (i_arm) state_d = StArmed;
      end
      StArmed: begin
        if (i_sample_valid && trigger) begin
          state_d  = StCapture;
          mem_we   = 1'b1;
          mem_addr = '0;
        end
      end
      StCapture: begin
        if (i_sample_valid) begin
          mem_we = 1'b1;
          if (wr_ptr_q == LastIdx) state_d = StReadout;
        end
      end
      StReadout: begin
        if (xfer && rd_ptr_q == LastIdx) state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (i_reset) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // Buffer contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_addr] <= i_sample;
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      prev_q    <= '0;
      prev_ok_q <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_arm) prev_ok_q <= 1'b0;
        end
        StArmed: begin
          if (i_sample_valid) begin
            prev_q    <= i_sample;
            prev_ok_q <= 1'b1;
            if (trigger) wr_ptr_q <= ptr_t'(1);
          end
        end
        StCapture: begin
          if (i_sample_valid) begin
            wr_ptr_q <= wr_ptr_q + ptr_t'(1);
            if (wr_ptr_q == LastIdx) begin
              rd_ptr_q <= '0;
              valid_q  <= 1'b0;
            end
          end
        end
        StReadout: begin
          if (!valid_q) begin
            // First cycle after entry: prime the registered read.
            data_q  <= mem[rd_ptr_q];
            valid_q <= 1'b1;
          end else if (i_ready) begin
            if (rd_ptr_q == LastIdx) begin
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              rd_ptr_q <= rd_next;
              data_q   <= mem[rd_next];
            end
          end
        end
      endcase
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_done  = done_q;
  assign o_state = state_q;

endmodule

// File: tb/tb_filter_capture.sv
// Directed bench for filter_capture: trigger cases, signed boundary, backpressure,
// capture gaps, ignored inputs and mid-capture reset.
module tb_filter_capture;

  logic       clock = 1'b0;
  logic       i_reset, i_sample_valid, i_arm, i_ready;
  logic [7:0] i_sample, i_threshold, o_data;
  logic       o_valid, o_done;
  logic [1:0] o_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q [$];

  filter_capture #(.N_PROBE(8), .N_DEPTH_LOG2(5)) dut (
    .clock          (clock),
    .i_reset        (i_reset),
    .i_sample       (i_sample),
    .i_sample_valid (i_sample_valid),
    .i_arm          (i_arm),
    .i_threshold    (i_threshold),
    .o_data         (o_data),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_state        (o_state),
    .o_done         (o_done)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic arm();
    i_arm = 1'b1;
    tick();
    i_arm = 1'b0;
  endtask

  task automatic send(input logic [7:0] s);
    i_sample       = s;
    i_sample_valid = 1'b1;
    tick();
    i_sample_valid = 1'b0;
  endtask

  // One valid cycle followed by two idle cycles, with an arm pulse in the gap.
  task automatic send_gap(input logic [7:0] s);
    send(s);
    i_sample = 8'hEE;
    i_arm    = 1'b1;
    tick();
    i_arm    = 1'b0;
    tick();
  endtask

  // stall: i_ready follows 1,0,0,1; noise: arm/valid pulses during readout.
  task automatic readout(input bit stall, input bit noise);
    int idx = 0;
    int cyc = 0;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    while (idx < 32 && cyc < 400) begin
      i_ready = stall ? pat[cyc % 4] : 1'b1;
      if (noise) begin
        i_arm          = (cyc % 5 == 2);
        i_sample_valid = (cyc % 3 == 0);
        i_sample       = 8'h5A;
      end
      check("rd_done_low", o_done, 0);
      check("rd_state", o_state, 2'b11);
      if (o_valid) begin
        check("rd_data", o_data, exp_q[idx]);
        if (i_ready) idx++;
      end
      tick();
      cyc++;
    end
    i_arm          = 1'b0;
    i_sample_valid = 1'b0;
    check("rd_count", idx, 32);
    check("done_pulse", o_done, 1);
    check("valid_end", o_valid, 0);
    check("state_end", o_state, 2'b00);
    i_ready = 1'b0;
    tick();
    check("done_clear", o_done, 0);
    check("state_idle", o_state, 2'b00);
  endtask

  initial begin
    i_reset        = 1'b1;
    i_sample       = '0;
    i_sample_valid = 1'b0;
    i_arm          = 1'b0;
    i_ready        = 1'b0;
    i_threshold    = 8'd0;
    tick();
    tick();
    i_reset = 1'b0;
    check("rst_state", o_state, 2'b00);
    check("rst_valid", o_valid, 0);
    check("rst_done", o_done, 0);
    check("rst_data", o_data, 0);

    // Reset in the middle of a capture.
    arm();
    check("arm1", o_state, 2'b01);
    send(8'hFB); send(8'hFF); send(8'd3); send(8'd7); send(8'd11);
    check("mid_capture", o_state, 2'b10);
    i_reset = 1'b1;
    repeat (5) tick();
    i_reset = 1'b0;
    check("abort_state", o_state, 2'b00);
    check("abort_valid", o_valid, 0);
    check("abort_done", o_done, 0);
    tick();
    check("abort_hold", o_state, 2'b00);
    arm();
    check("rearm", o_state, 2'b01);

    // Basic trigger at threshold 0: -5, -1 then trigger on 3.
    send(8'hFB);
    check("basic_m5", o_state, 2'b01);
    send(8'hFF);
    check("basic_m1", o_state, 2'b01);
    send(8'd3);
    check("basic_trig", o_state, 2'b10);
    exp_q = {};
    exp_q.push_back(8'd3);
    for (int k = 1; k < 32; k++) begin
      send(8'(3 + 4 * k));
      exp_q.push_back(8'(3 + 4 * k));
    end
    check("basic_full", o_state, 2'b11);
    readout(1'b0, 1'b0);

    // Signed boundary at -10; capture with gaps, stalled noisy readout.
    i_threshold = 8'hF6;
    arm();
    send(8'h7F);
    check("sb_127", o_state, 2'b01);
    send(8'h80);
    check("sb_m128", o_state, 2'b01);
    send(8'hF5);
    check("sb_m11", o_state, 2'b01);
    send(8'hF6);
    check("sb_trig", o_state, 2'b10);
    exp_q = {};
    exp_q.push_back(8'hF6);
    for (int k = 1; k < 32; k++) begin
      send_gap(8'(k * 7));
      exp_q.push_back(8'(k * 7));
      if (k < 31) check("gap_state", o_state, 2'b10);
    end
    check("gap_full", o_state, 2'b11);
    readout(1'b1, 1'b1);

    // No false trigger on first sample after arm.
    i_threshold = 8'd20;
    send(8'd0);
    check("idle_ignore", o_state, 2'b00);
    arm();
    send(8'd50);
    check("nf_first", o_state, 2'b01);
    send(8'd10);
    check("nf_below", o_state, 2'b01);
    send(8'd25);
    check("nf_trig", o_state, 2'b10);
    exp_q = {};
    exp_q.push_back(8'd25);
    for (int k = 1; k < 32; k++) begin
      send(8'(8'h80 + k));
      exp_q.push_back(8'(8'h80 + k));
    end
    check("nf_full", o_state, 2'b11);
    readout(1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
